// File: rtl/neg_arbiter_if.sv
// Request/grant and result bus between the RDFT butterfly stages and the shared
// complex negation unit. Operands are packed per requester as [i*W +: W].
interface neg_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_re;
  logic [NREQ*W-1:0] req_im;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_re;
  logic [W-1:0]      rsp_im;
  logic              rsp_ovf;
  logic              rsp_ready;

  modport master (
    output req, req_re, req_im, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_re, rsp_im, rsp_ovf
  );

  modport slave (
    input  req, req_re, req_im, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_re, rsp_im, rsp_ovf
  );
endinterface

// File: rtl/neg_arbiter.sv
// Round-robin shared complex negation unit (out = -in) for the RDFT stages that need
// a W^(N/2) = -1 product; one-entry registered result with rsp_ready backpressure.
module neg_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  neg_arbiter_if.slave  bus
);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_re_q, rsp_re_d;
  logic [W-1:0]   rsp_im_q, rsp_im_d;
  logic           rsp_ovf_q, rsp_ovf_d;

  logic            accept;
  logic [NREQ-1:0] gnt;
  logic            grant_any;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    search_sum;
  logic [IDW-1:0]  search_idx;
  logic [W-1:0]    sel_re;
  logic [W-1:0]    sel_im;

  // accept also carries rst so gnt is held low combinationally during reset
  assign accept = rst & (~rsp_valid_q | bus.rsp_ready);

  // Search ptr, ptr+1, ..., wrapping at NREQ; first requester found wins
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    grant_any  = 1'b0;
    search_sum = '0;
    search_idx = '0;
    if (accept) begin
      for (int k = 0; k < NREQ; k++) begin
        search_sum = {1'b0, ptr_q} + (IDW+1)'(k);
        if (search_sum >= (IDW+1)'(NREQ)) begin
          search_sum = search_sum - (IDW+1)'(NREQ);
        end
        search_idx = search_sum[IDW-1:0];
        if (!grant_any && bus.req[search_idx]) begin
          gnt[search_idx] = 1'b1;
          gnt_idx         = search_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_re = bus.req_re[i*W +: W];
        sel_im = bus.req_im[i*W +: W];
      end
    end
  end

  // A new grant overwrites the result even when it is being consumed this edge
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_re_d    = rsp_re_q;
    rsp_im_d    = rsp_im_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (grant_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_re_d    = -sel_re;
      rsp_im_d    = -sel_im;
      rsp_ovf_d   = (sel_re == MIN_VAL) | (sel_im == MIN_VAL);
      ptr_d       = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_re_q    <= '0;
      rsp_im_q    <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_re_q    <= rsp_re_d;
      rsp_im_q    <= rsp_im_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_re    = rsp_re_q;
  assign bus.rsp_im    = rsp_im_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

  // A stalled result must not move under the consumer
  gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
  stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (rsp_valid_q && !bus.rsp_ready) |=> ($stable(rsp_re_q) && $stable(rsp_im_q) &&
                                         $stable(rsp_id_q) && rsp_valid_q));

endmodule

// File: tb/tb_neg_arbiter.sv
// Directed table-driven bench for neg_arbiter, plus fairness and starvation sequences.
module tb_neg_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
  localparam logic [31:0] MINV = 32'h8000_0000;

  typedef struct {
    logic         rstN;
    logic [3:0]   req;
    logic [127:0] re;
    logic [127:0] im;
    logic         ready;
    logic [3:0]   expGnt;
    logic         chkRsp;
    logic         expValid;
    logic [1:0]   expId;
    logic [31:0]  expRe;
    logic [31:0]  expIm;
    logic         expOvf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  neg_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

  neg_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] packOps(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic addVec(input logic rstN, input logic [3:0] req, input logic [127:0] re,
                        input logic [127:0] im, input logic ready, input logic [3:0] expGnt,
                        input logic chkRsp, input logic expValid, input logic [1:0] expId,
                        input logic [31:0] expRe, input logic [31:0] expIm, input logic expOvf);
    vec_t v;
    v.rstN = rstN; v.req = req; v.re = re; v.im = im; v.ready = ready;
    v.expGnt = expGnt; v.chkRsp = chkRsp; v.expValid = expValid; v.expId = expId;
    v.expRe = expRe; v.expIm = expIm; v.expOvf = expOvf;
    vecs.push_back(v);
  endtask

  task automatic checkField(input string name, input int row, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL row %0d %s: got %h want %h", row, name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst           = v.rstN;
    bus.req       = v.req;
    bus.req_re    = v.re;
    bus.req_im    = v.im;
    bus.rsp_ready = v.ready;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    checkField("gnt", row, 32'(bus.gnt), 32'(v.expGnt));
    if (v.chkRsp) begin
      checkField("rsp_valid", row, 32'(bus.rsp_valid), 32'(v.expValid));
      checkField("rsp_id", row, 32'(bus.rsp_id), 32'(v.expId));
      checkField("rsp_re", row, bus.rsp_re, v.expRe);
      checkField("rsp_im", row, bus.rsp_im, v.expIm);
      checkField("rsp_ovf", row, 32'(bus.rsp_ovf), 32'(v.expOvf));
    end
  endtask

  initial begin
    logic [127:0] bRe, bIm, r3, i3, r16, i16, r18, i18, r22, i22;
    int  cnt [NREQ];
    int  acceptCnt;
    logic granted;

    rst = 1'b0;
    bus.req = '0;
    bus.req_re = '0;
    bus.req_im = '0;
    bus.rsp_ready = 1'b0;

    bRe = packOps(100, 101, 102, 103);
    bIm = packOps(-200, -201, -202, -203);
    r3  = packOps(100, 101, 5, 103);
    i3  = packOps(-200, -201, -3, -203);
    r16 = packOps(MINV, 101, 102, 103);
    i16 = packOps(1, -201, -202, -203);
    r18 = packOps(100, 101, 102, 0);
    i18 = packOps(-200, -201, -202, 0);
    r22 = packOps(100, 7, 102, 103);
    i22 = packOps(-200, MINV, -202, -203);

    // Each row: inputs for this cycle, gnt for this cycle, result from the previous edge
    addVec(0, 4'b1111, bRe, bIm, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    addVec(0, 4'b1111, bRe, bIm, 1, 4'b0000, 1, 0, 0, 0, 0, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b0001, 1, 0, 0, 0, 0, 0);
    addVec(1, 4'b0100, r3,  i3,  1, 4'b0100, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0000, r3,  i3,  1, 4'b0000, 1, 1, 2, -5, 3, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b1000, 1, 0, 2, -5, 3, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b0001, 1, 1, 3, -103, 203, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b0010, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b0100, 1, 1, 1, -101, 201, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b1000, 1, 1, 2, -102, 202, 0);
    addVec(1, 4'b1111, bRe, bIm, 1, 4'b0001, 1, 1, 3, -103, 203, 0);
    addVec(1, 4'b0011, bRe, bIm, 0, 4'b0000, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0011, bRe, bIm, 0, 4'b0000, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0011, bRe, bIm, 0, 4'b0000, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0011, bRe, bIm, 1, 4'b0010, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0000, bRe, bIm, 1, 4'b0000, 1, 1, 1, -101, 201, 0);
    addVec(1, 4'b0001, r16, i16, 1, 4'b0001, 1, 0, 1, -101, 201, 0);
    addVec(1, 4'b0000, r16, i16, 0, 4'b0000, 1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    addVec(0, 4'b1001, r18, i18, 0, 4'b0000, 1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    addVec(1, 4'b1001, r18, i18, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    addVec(1, 4'b1000, r18, i18, 1, 4'b1000, 1, 1, 0, -100, 200, 0);
    addVec(1, 4'b0000, r18, i18, 1, 4'b0000, 1, 1, 3, 0, 0, 0);
    addVec(1, 4'b0010, r22, i22, 1, 4'b0010, 1, 0, 3, 0, 0, 0);
    addVec(1, 4'b0000, r22, i22, 1, 4'b0000, 1, 1, 1, -7, MINV, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      applyStimulus(vecs[r]);
      #1;
      checkOutput(r, vecs[r]);
    end

    // Fairness: all requesting with ready high, each requester gets 2 of 8 grants
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.req = 4'b1111;
      bus.req_re = bRe;
      bus.req_im = bIm;
      bus.rsp_ready = 1'b1;
      #1;
      checkField("gnt_count1", 100 + c, 32'($countones(bus.gnt)), 1);
      for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) cnt[k]++;
    end
    for (int k = 0; k < NREQ; k++) checkField("fair_count", 200 + k, cnt[k], 2);

    // Starvation: ptr sits at 2, so requester 1 is the 4th accept cycle under stalls
    acceptCnt = 0;
    granted = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.rsp_ready = (c % 3 == 2);
      #1;
      if (!bus.rsp_valid || bus.rsp_ready) acceptCnt++;
      if (bus.gnt[1]) begin
        granted = 1'b1;
        break;
      end
    end
    checkField("starve_granted", 300, 32'(granted), 1);
    checkField("starve_accepts", 301, acceptCnt, NREQ);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
